// File: rtl/systolic_skew_feeder.sv
// ---------------------------------------------------------------------------
// systolic_skew_feeder
//
// Row-vector feeder for the west edge of the systolic array. Incoming N-lane
// vectors are buffered in a FIFO and released in whole tiles of TILE_K
// vectors. Lane i of each released vector is delayed i cycles (diagonal skew)
// so every PE row sees its operand on the correct wavefront. Each tile is
// followed by N-1 cycles of zero injection so the last wavefront can drain
// before the next tile starts. Everything except FIFO push advances only on
// edges where array_en is high.
//
// Ports
//   clk         clock, all state on posedge
//   reset       synchronous, active-high
//   in_data     N*DATA_WIDTH input vector, lane i = [i*DATA_WIDTH +: DATA_WIDTH]
//   in_valid    in_data valid
//   in_ready    FIFO can accept (push on in_valid && in_ready)
//   array_en    array-wide advance enable, stall when low
//   skew_data   skewed lanes to the array west edge
//   skew_valid  per-lane valid, travels with skew_data
//   tile_start  pulse: first vector of a tile popped
//   tile_done   pulse: last vector of the tile present on lane N-1
//   fifo_count  FIFO occupancy (only when SKEW_FEEDER_STATUS_EN is defined)
//
// Build option
//   SKEW_FEEDER_STATUS_EN  adds the fifo_count status port.
// ---------------------------------------------------------------------------
module systolic_skew_feeder #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int TILE_K     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N*DATA_WIDTH-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    array_en,
  output logic [N*DATA_WIDTH-1:0] skew_data,
  output logic [N-1:0]            skew_valid,
  output logic                    tile_start,
  output logic                    tile_done
`ifdef SKEW_FEEDER_STATUS_EN
  ,
  output logic [$clog2(DEPTH):0]  fifo_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int VW = $clog2(TILE_K + 1);
  localparam int DW = $clog2(N);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] TILE_CNT = CW'(TILE_K);
  localparam logic [VW-1:0] LAST_VEC = VW'(TILE_K - 1);
  localparam logic [DW-1:0] LAST_DRN = DW'(N - 2);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  // FIFO storage and control
  logic [N*DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]           r_wr_ptr;
  logic [AW-1:0]           r_rd_ptr;
  logic [CW-1:0]           r_count;
  logic                    w_full;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_tile_avail;
  logic [N*DATA_WIDTH-1:0] w_head;

  // Tile sequencing
  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [VW-1:0]           r_vec_cnt;
  logic [VW-1:0]           w_vec_cnt_nxt;
  logic [DW-1:0]           r_drn_cnt;
  logic [DW-1:0]           w_drn_cnt_nxt;
  logic                    w_start;
  logic                    w_done;
  logic                    r_tile_start;
  logic                    r_tile_done;

  assign w_full       = (r_count == FULL_CNT);
  // Ready deliberately ignores a same-cycle pop: a full FIFO never pushes.
  assign in_ready     = ~w_full & ~reset;
  assign w_push       = in_valid & in_ready;
  assign w_tile_avail = (r_count >= TILE_CNT);
  assign w_head       = r_mem[r_rd_ptr];

  // FIFO storage: data only, no reset needed
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_vec_cnt    <= '0;
      r_drn_cnt    <= '0;
      r_tile_start <= 1'b0;
      r_tile_done  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_vec_cnt    <= w_vec_cnt_nxt;
      r_drn_cnt    <= w_drn_cnt_nxt;
      // Strobes are only raised on enabled edges, so a stall drops them to 0.
      r_tile_start <= w_start;
      r_tile_done  <= w_done;
    end
  end

  // Next-state / pop decode; nothing moves on a stalled edge
  always_comb begin
    w_state_nxt   = r_state;
    w_vec_cnt_nxt = r_vec_cnt;
    w_drn_cnt_nxt = r_drn_cnt;
    w_pop         = 1'b0;
    w_start       = 1'b0;
    w_done        = 1'b0;
    if (array_en) begin
      case (r_state)
        S_IDLE: begin
          if (w_tile_avail) begin
            w_pop   = 1'b1;
            w_start = 1'b1;
            if (TILE_K == 1) begin
              w_state_nxt   = S_DRAIN;
              w_drn_cnt_nxt = '0;
            end else begin
              w_state_nxt   = S_STREAM;
              w_vec_cnt_nxt = VW'(1);
            end
          end
        end
        S_STREAM: begin
          w_pop = 1'b1;
          // Entered from DRAIN with the counter at 0: this edge opens the tile.
          w_start = (r_vec_cnt == '0);
          if (r_vec_cnt == LAST_VEC) begin
            w_state_nxt   = S_DRAIN;
            w_drn_cnt_nxt = '0;
          end else begin
            w_vec_cnt_nxt = r_vec_cnt + VW'(1);
          end
        end
        S_DRAIN: begin
          if (r_drn_cnt == LAST_DRN) begin
            w_done = 1'b1;
            if (w_tile_avail) begin
              w_state_nxt   = S_STREAM;
              w_vec_cnt_nxt = '0;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_drn_cnt_nxt = r_drn_cnt + DW'(1);
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign tile_start = r_tile_start;
  assign tile_done  = r_tile_done;

  // Skew chains: lane i has i+1 register stages, stage 0 loads from the pop
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      logic [DATA_WIDTH-1:0] r_lane_p [gi+1];
      logic [gi:0]           r_lane_vld_p;
      logic [DATA_WIDTH-1:0] w_lane_in;

      // Non-popping edges inject zero so invalid slots always read as zero.
      assign w_lane_in = w_pop ? w_head[gi*DATA_WIDTH +: DATA_WIDTH] : '0;

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int s = 0; s <= gi; s++) begin
            r_lane_p[s]     <= '0;
            r_lane_vld_p[s] <= 1'b0;
          end
        end else if (array_en) begin
          r_lane_p[0]     <= w_lane_in;
          r_lane_vld_p[0] <= w_pop;
          for (int s = 1; s <= gi; s++) begin
            r_lane_p[s]     <= r_lane_p[s-1];
            r_lane_vld_p[s] <= r_lane_vld_p[s-1];
          end
        end
      end

      assign skew_data[gi*DATA_WIDTH +: DATA_WIDTH] = r_lane_p[gi];
      assign skew_valid[gi]                         = r_lane_vld_p[gi];
    end
  endgenerate

`ifdef SKEW_FEEDER_STATUS_EN
  assign fifo_count = r_count;
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// ---------------------------------------------------------------------------
// tb_systolic_skew_feeder
//
// Directed bench for systolic_skew_feeder at N=4, DATA_WIDTH=8, DEPTH=8,
// TILE_K=4. Expected skew outputs come from a small tile model: with a tile
// period of 7 enabled cycles, lane i at enabled cycle c carries vector
// (c-i) mod 7 of tile (c-i)/7 when that index is below 4.
// ---------------------------------------------------------------------------
module tb_systolic_skew_feeder;

  localparam int N      = 4;
  localparam int DW     = 8;
  localparam int DEPTH  = 8;
  localparam int TILE_K = 4;
  localparam int PERIOD = TILE_K + N - 1;

  logic            clk;
  logic            reset;
  logic [N*DW-1:0] in_data;
  logic            in_valid;
  logic            in_ready;
  logic            array_en;
  logic [N*DW-1:0] skew_data;
  logic [N-1:0]    skew_valid;
  logic            tile_start;
  logic            tile_done;
`ifdef SKEW_FEEDER_STATUS_EN
  logic [3:0]      fifo_count;
`endif

  systolic_skew_feeder #(
    .N(N), .DATA_WIDTH(DW), .DEPTH(DEPTH), .TILE_K(TILE_K)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .array_en   (array_en),
    .skew_data  (skew_data),
    .skew_valid (skew_valid),
    .tile_start (tile_start),
    .tile_done  (tile_done)
`ifdef SKEW_FEEDER_STATUS_EN
    ,
    .fifo_count (fifo_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk;
  int          n_pass;
  logic [31:0] tv [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_tv(input logic [31:0] base);
    for (int k = 0; k < 16; k++) tv[k] = base + 32'(k) * 32'h04040404;
  endtask

  function automatic logic [31:0] exp_data(input int c, input int ntiles);
    logic [31:0] r;
    logic [31:0] v;
    int k, t, j;
    r = '0;
    for (int i = 0; i < N; i++) begin
      k = c - i;
      if (k >= 0) begin
        t = k / PERIOD;
        j = k % PERIOD;
        if (t < ntiles && j < TILE_K) begin
          v = tv[TILE_K*t + j];
          r[DW*i +: DW] = v[DW*i +: DW];
        end
      end
    end
    return r;
  endfunction

  function automatic logic [3:0] exp_valid(input int c, input int ntiles);
    logic [3:0] r;
    int k;
    r = '0;
    for (int i = 0; i < N; i++) begin
      k = c - i;
      if (k >= 0 && (k / PERIOD) < ntiles && (k % PERIOD) < TILE_K) r[i] = 1'b1;
    end
    return r;
  endfunction

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    array_en = 1'b1;
    tick();
    tick();
    check("rst_data",  skew_data,  32'h0);
    check("rst_valid", skew_valid, 32'h0);
    check("rst_start", tile_start, 32'h0);
    check("rst_done",  tile_done,  32'h0);
    check("rst_ready", in_ready,   32'h0);
    reset = 1'b0;
    #1;
    check("rst_ready_after", in_ready, 32'h1);
  endtask

  // Runs a scenario: pre vectors already queued in tv[0..pre-1], nvec more
  // pushed back-to-back from tv[pre..], ntiles expected tiles, optional stall
  // of stall_len edges once enabled cycle stall_at has been reached.
  task automatic run_scn(input string tag, input int pre, input int nvec, input int ntiles,
                         input int stall_at, input int stall_len, input int ncyc);
    int   pidx;
    int   mcount;
    int   c;
    int   scnt;
    bit   started;
    bit   en;
    bit   push;
    bit   st_now;
    pidx    = 0;
    mcount  = pre;
    c       = 0;
    scnt    = 0;
    started = 1'b0;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      en = !(started && c == stall_at && scnt < stall_len);
      if (!en) scnt++;
      in_valid = (pidx < nvec);
      in_data  = in_valid ? tv[pre + pidx] : '0;
      array_en = en;
      push     = in_valid && (mcount < DEPTH);
      st_now   = en && !started && (mcount >= TILE_K);
      tick();
      if (push) begin
        pidx++;
        mcount++;
      end
      if (st_now) begin
        started = 1'b1;
        c       = 0;
      end else if (started && en) begin
        c++;
      end
      if (started && en && (c % PERIOD) < TILE_K && (c / PERIOD) < ntiles) mcount--;
      if (started) begin
        check($sformatf("%s_data_c%0d", tag, c), skew_data, exp_data(c, ntiles));
        check($sformatf("%s_vld_c%0d", tag, c), skew_valid, exp_valid(c, ntiles));
        check($sformatf("%s_start_c%0d", tag, c), tile_start,
              en && (c % PERIOD) == 0 && (c / PERIOD) < ntiles);
        check($sformatf("%s_done_c%0d", tag, c), tile_done,
              en && (c % PERIOD) == PERIOD - 1 && (c / PERIOD) < ntiles);
      end else begin
        check($sformatf("%s_idle_vld%0d", tag, cyc), skew_valid, 32'h0);
        check($sformatf("%s_idle_start%0d", tag, cyc), tile_start, 32'h0);
      end
      check($sformatf("%s_ready%0d", tag, cyc), in_ready, (mcount < DEPTH));
    end
    in_valid = 1'b0;
    array_en = 1'b1;
  endtask

  initial begin
    n_chk    = 0;
    n_pass   = 0;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    array_en = 1'b1;

    // Single tile, first 3 vectors must not start streaming
    do_reset();
    fill_tv(32'h04030201);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = tv[k];
      tick();
      check("three_vld", skew_valid, 32'h0);
    end
    in_valid = 1'b0;
    tick();
    tick();
    check("three_idle_vld",   skew_valid, 32'h0);
    check("three_idle_start", tile_start, 32'h0);
    in_valid = 1'b1;
    in_data  = tv[3];
    tick();
    in_valid = 1'b0;
    check("fourth_push_vld", skew_valid, 32'h0);
    run_scn("tile1", 4, 0, 1, -1, 0, 9);

    // Two back-to-back tiles from continuous pushes
    do_reset();
    fill_tv(32'h81726354);
    run_scn("tile2", 0, 8, 2, -1, 0, 19);

    // Stall for 5 edges mid-STREAM
    do_reset();
    fill_tv(32'h30201000);
    run_scn("stall", 0, 4, 1, 1, 5, 17);

    // Fill to DEPTH while stalled; extra pushes must be dropped
    do_reset();
    fill_tv(32'h50403020);
    tv[8] = 32'hDEADBEEF;
    tv[9] = 32'hCAFEF00D;
    for (int k = 0; k < 10; k++) begin
      array_en = 1'b0;
      in_valid = 1'b1;
      in_data  = tv[k];
      tick();
      check($sformatf("fill_ready%0d", k), in_ready, (k < DEPTH - 1));
      check($sformatf("fill_vld%0d", k), skew_valid, 32'h0);
    end
    in_valid = 1'b0;
`ifdef SKEW_FEEDER_STATUS_EN
    check("fill_count", fifo_count, 32'd8);
`endif
    run_scn("full", 8, 0, 2, -1, 0, 17);

    // Reset asserted during DRAIN with 3 vectors still queued
    do_reset();
    fill_tv(32'h01020304);
    run_scn("pre_rst", 0, 7, 1, -1, 0, 10);
    reset = 1'b1;
    tick();
    check("drn_rst_data",  skew_data,  32'h0);
    check("drn_rst_vld",   skew_valid, 32'h0);
    check("drn_rst_start", tile_start, 32'h0);
    check("drn_rst_done",  tile_done,  32'h0);
    check("drn_rst_ready", in_ready,   32'h0);
    reset = 1'b0;
    #1;
    check("drn_rst_ready_after", in_ready, 32'h1);
`ifdef SKEW_FEEDER_STATUS_EN
    check("drn_rst_count", fifo_count, 32'd0);
`endif
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("post_rst_vld%0d", k), skew_valid, 32'h0);
      check($sformatf("post_rst_data%0d", k), skew_data, 32'h0);
      check($sformatf("post_rst_start%0d", k), tile_start, 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

Row-vector feeder between the AXI-stream input slave and the west edge of the systolic array. Buffers incoming N-lane vectors in a FIFO, releases them in whole tiles of TILE_K vectors, and applies diagonal skew (lane i delayed i cycles) so each PE row receives its operands on the correct wavefront. Inserts an (N-1)-cycle zero drain after each tile and honours the array-wide stall enable.

## Interface
- N, 4, lanes per vector / array rows; N ≥ 2
- DATA_WIDTH, 8, bits per lane
- DEPTH, 8, FIFO entries; power of two, DEPTH ≥ TILE_K
- TILE_K, 4, vectors per tile; ≥ 1
- clk  in  1  clock, all state on posedge
- reset  in  1  synchronous, active-high
- in_data  in  N*DATA_WIDTH  vector from input slave; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH]
- in_valid  in  1  in_data valid
- in_ready  out  1  FIFO can accept; push when in_valid && in_ready
- array_en  in  1  array-wide advance enable (stall when 0)
- skew_data  out  N*DATA_WIDTH  skewed lanes to array west edge
- skew_valid  out  N  per-lane valid, travels with skew_data
- tile_start  out  1  pulse: first vector of a tile popped
- tile_done  out  1  pulse: last vector of tile present on lane N-1
- fifo_count  out  $clog2(DEPTH)+1  occupancy (only with SKEW_FEEDER_STATUS_EN)

## Operation
- FIFO: push on in_valid && in_ready; in_ready = ~full && ~reset (combinational). When full, no push even if a pop occurs same cycle. Push independent of array_en.
- FSM states IDLE, STREAM, DRAIN; all transitions, pops and skew shifts occur only on edges with array_en=1.
- IDLE → STREAM when count ≥ TILE_K; that edge pops vector 0 and pulses tile_start.
- STREAM: pop one vector per enabled edge; vector counter 0..TILE_K-1. Transition to DRAIN on edge popping vector TILE_K-1 (TILE_K=1: IDLE→DRAIN directly, tile_start still pulses).
- DRAIN: N-1 enabled edges injecting zero data, valid 0 into lane 0. On final drain edge pulse tile_done; next state STREAM (with pop + tile_start) if count ≥ TILE_K, else IDLE.
- Skew: lane 0 output register loads popped lane 0 (or zero/0 valid when not popping); lane i is an i-stage shift chain from the popped lane i. Invalid lanes output zero data.
- Data values pass unmodified; no arithmetic.

## Timing
- Reset: skew_data=0, skew_valid=0, tile_start=0, tile_done=0, FIFO empty, FSM IDLE, counters 0; in_ready=0 during reset, 1 on first cycle after.
- Vector popped on edge e: lane i visible after edge e+i (enabled edges only). FIFO-write to first possible pop: 1 cycle.
- tile_done registered on edge aligning with lane N-1 showing the tile's last vector.
- array_en=0: skew_data, skew_valid, FSM, counters hold; tile_start/tile_done forced 0 that cycle (no re-pulse).
- Back-to-back tiles: tile period = TILE_K + N-1 enabled cycles.
- Reset mid-tile: all in-flight data and FIFO contents discarded; returns to reset values next cycle.

## Configuration
- SKEW_FEEDER_STATUS_EN: defined → fifo_count port present, equals FIFO occupancy after each edge (0..DEPTH). Undefined → port and logic absent; all other behaviour identical.

## Test plan
- N=4, TILE_K=4: push vectors 0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D, array_en=1 → lane0 01,05,09,0D on consecutive cycles; lane3 04,08,0C,10 starting 3 cycles after lane0; tile_start one pulse; tile_done with lane3=0x10.
- Push only 3 vectors → stays IDLE, skew_valid=0; 4th push → streaming begins next cycle.
- Push 8 vectors continuously → two tiles separated by exactly 3 drain cycles of skew_valid[0]=0.
- Drop array_en for 5 cycles mid-STREAM → outputs frozen, no lost/duplicated vectors, no repeated pulses.
- Fill FIFO to DEPTH=8 with array_en=0 → in_ready=0, extra in_valid ignored, fifo_count=8; release → in_ready=1 after first pop.
- Assert reset during DRAIN → all outputs 0, in_ready=1 after release, no stale data emitted.
